fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
Shares the single write port of Asynchronous_FIFO between NUM_REQ producers in the write_clk domain. It runs round-robin arbitration with bounded bursts, honours w_full back-pressure without losing or duplicating words, and reports ownership and stall statistics. The block sits directly in front of the FIFO's write side; its w_en/w_data outputs drive the FIFO and its w_full input comes from the FIFO.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, word width; matches the FIFO data width
MAX_BURST, 4, maximum words per grant (1..15)

Ports:
write_clk  input  1  write-domain clock; all logic on the rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester word-valid
req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-requester accept; a word transfers when valid and ready are both 1
w_full  input  1  FIFO full flag (write domain)
w_en  output  1  FIFO write strobe
w_data  output  DATA_WIDTH  FIFO write data
owner_id  output  clog2(NUM_REQ)  current grant holder
owner_valid  output  1  1 while in GRANT
stall_cnt  output  16  saturating count of cycles in GRANT with owner valid and w_full=1

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr_ptr=0, burst_cnt=0, owner_id=0, owner_valid=0, stall_cnt=0. All req_ready=0, w_en=0, w_data=0. A mid-burst reset drops the grant immediately. No partial write is issued after reset asserts.
- FSM states:
  - IDLE: if any req_valid bit is set, select the first set bit scanning from rr_ptr upward with wrap. Register it in owner_id, clear burst_cnt, and go to GRANT. No transfer happens in IDLE; this gives one arbitration cycle per burst.
  - GRANT: req_ready[owner_id] = !w_full (combinational). All other req_ready bits are 0.
    - Transfer when req_valid[owner_id] && !w_full. In that cycle w_en=1 and w_data=req_data[owner_id] combinationally (zero latency), and burst_cnt increments.
    - Go to IDLE when the transfer makes burst_cnt reach MAX_BURST, or when req_valid[owner_id]=0 (no transfer in that cycle).
    - w_full=1 stalls the burst: no transfer, no exit, and burst_cnt is held.
  - On leaving GRANT: rr_ptr = owner_id+1, wrapping to 0 at NUM_REQ.
- w_en is never 1 while w_full=1. w_data is 0 when w_en=0.
- stall_cnt increments in GRANT when req_valid[owner_id] && w_full. It saturates at 0xFFFF.
- Requester contract: once req_valid is raised it holds, with data stable, until accepted. The arbiter does not check this.
- Simultaneous events:
  - The owner drops valid in the same cycle w_full rises: exit to IDLE with no stall count.
  - The last burst word while other requesters are pending: the next owner is chosen in the following IDLE cycle.
- Throughput: MAX_BURST words per MAX_BURST+1 cycles when not stalled.

Test Plan:
- Reset then single requester: req_valid=4'b0001, data 0x10..0x17, w_full=0. Expect words written as 0x10,0x11,0x12,0x13, then one IDLE cycle, then 0x14..0x17. w_en pattern is 1111_0_1111.
- Round-robin fairness: all four requesters always valid. Expect owner_id sequence 0,1,2,3,0, each holding for 4 writes, and rr_ptr wrapping from 3 to 0.
- Back-pressure: owner 2 mid-burst with burst_cnt=2, w_full=1 for 5 cycles. Expect w_en=0 and req_ready[2]=0 for those cycles, stall_cnt=5, burst_cnt held at 2. After release, exactly 2 more words are written.
- Early release: owner 1 drops valid after 2 words. Expect return to IDLE, rr_ptr=2, and requester 3 (only other valid) granted next with owner_id=3.
- Async reset mid-burst: assert reset=0 between clock edges during GRANT. Expect w_en, req_ready, owner_valid and stall_cnt at 0 immediately. After deassert, arbitration restarts from requester 0.
- Saturation: hold w_full=1 with owner valid for 70000 cycles. Expect stall_cnt=0xFFFF and no wrap.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for the async FIFO write side.
// Bounded bursts, w_full back-pressure, ownership and stall statistics.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          write_clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          w_full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [IDW-1:0]                owner_id,
    output logic                          owner_valid,
    output logic [15:0]                   stall_cnt
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDW-1:0]        r_owner;
    logic [IDW-1:0]        r_rr_ptr;
    logic [3:0]            r_burst;
    logic [15:0]           r_stall;
    logic [IDW-1:0]        w_owner_nxt;
    logic [IDW-1:0]        w_rr_nxt;
    logic [IDW-1:0]        w_rr_inc;
    logic [3:0]            w_burst_nxt;
    logic [IDW-1:0]        w_pick;
    logic                  w_pick_vld;
    logic                  w_grant;
    logic                  w_own_vld;
    logic                  w_xfer;
    logic                  w_stall;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign w_words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_grant   = (r_state == S_GRANT);
    assign w_own_vld = req_valid[r_owner];
    assign w_xfer    = w_grant && w_own_vld && !w_full;
    assign w_stall   = w_grant && w_own_vld && w_full;
    assign w_last    = (r_burst == 4'(MAX_BURST - 1));
    assign w_rr_inc  = (r_owner == IDW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        logic [IDW-1:0] idx;
        w_pick     = '0;
        w_pick_vld = 1'b0;
        idx        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDW'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (req_valid[idx]) begin
                w_pick     = idx;
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_burst_nxt = r_burst;
        w_rr_nxt    = r_rr_ptr;
        unique case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_owner_nxt = w_pick;
                    w_burst_nxt = '0;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!w_own_vld) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = w_rr_inc;
                end else if (w_xfer) begin
                    w_burst_nxt = r_burst + 4'd1;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                        w_rr_nxt    = w_rr_inc;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge write_clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_burst  <= '0;
            r_stall  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_burst  <= w_burst_nxt;
            if (w_stall && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[r_owner] = !w_full;
        end
    end

    assign w_en        = w_xfer;
    assign w_data      = w_xfer ? w_words[r_owner] : '0;
    assign owner_id    = r_owner;
    assign owner_valid = w_grant;
    assign stall_cnt   = r_stall;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: vector table plus
// hand-written multi-cycle sequences.
module tb_fifo_write_arbiter;

    logic        write_clk = 1'b0;
    logic        reset     = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_ready;
    logic        w_full    = 1'b0;
    logic        w_en;
    logic [7:0]  w_data;
    logic [1:0]  owner_id;
    logic        owner_valid;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fifo_write_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .write_clk   (write_clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .w_full      (w_full),
        .w_en        (w_en),
        .w_data      (w_data),
        .owner_id    (owner_id),
        .owner_valid (owner_valid),
        .stall_cnt   (stall_cnt)
    );

    always #5 write_clk = ~write_clk;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic        f;
        logic        en;
        logic [7:0]  wd;
        logic [3:0]  rdy;
        logic [1:0]  own;
        logic        ov;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge write_clk);
        @(negedge write_clk);
    endtask

    task automatic reset_dut();
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        w_full    = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        int bad;
        int o;

        vt[0]  = '{4'h1, 32'h10, 1'b0, 1'b0, 8'h00, 4'h0, 2'd0, 1'b0};
        vt[1]  = '{4'h1, 32'h10, 1'b0, 1'b1, 8'h10, 4'h1, 2'd0, 1'b1};
        vt[2]  = '{4'h1, 32'h11, 1'b0, 1'b1, 8'h11, 4'h1, 2'd0, 1'b1};
        vt[3]  = '{4'h1, 32'h12, 1'b0, 1'b1, 8'h12, 4'h1, 2'd0, 1'b1};
        vt[4]  = '{4'h1, 32'h13, 1'b0, 1'b1, 8'h13, 4'h1, 2'd0, 1'b1};
        vt[5]  = '{4'h1, 32'h14, 1'b0, 1'b0, 8'h00, 4'h0, 2'd0, 1'b0};
        vt[6]  = '{4'h1, 32'h14, 1'b0, 1'b1, 8'h14, 4'h1, 2'd0, 1'b1};
        vt[7]  = '{4'h1, 32'h15, 1'b0, 1'b1, 8'h15, 4'h1, 2'd0, 1'b1};
        vt[8]  = '{4'h1, 32'h16, 1'b0, 1'b1, 8'h16, 4'h1, 2'd0, 1'b1};
        vt[9]  = '{4'h1, 32'h17, 1'b0, 1'b1, 8'h17, 4'h1, 2'd0, 1'b1};
        vt[10] = '{4'h0, 32'h00, 1'b0, 1'b0, 8'h00, 4'h0, 2'd0, 1'b0};

        // Reset state
        @(negedge write_clk);
        #1;
        chk("rst_en", 32'(w_en), 32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd0);
        chk("rst_ov", 32'(owner_valid), 32'd0);
        chk("rst_own", 32'(owner_id), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_wd", 32'(w_data), 32'd0);
        reset_dut();

        // Single requester, 1111_0_1111
        for (int i = 0; i < 11; i++) begin
            req_valid = vt[i].v;
            req_data  = vt[i].d;
            w_full    = vt[i].f;
            #1;
            chk($sformatf("v%0d_en", i), 32'(w_en), 32'(vt[i].en));
            chk($sformatf("v%0d_wd", i), 32'(w_data), 32'(vt[i].wd));
            chk($sformatf("v%0d_rdy", i), 32'(req_ready), 32'(vt[i].rdy));
            chk($sformatf("v%0d_own", i), 32'(owner_id), 32'(vt[i].own));
            chk($sformatf("v%0d_ov", i), 32'(owner_valid), 32'(vt[i].ov));
            cyc();
        end

        // Round-robin with all requesters valid
        reset_dut();
        req_valid = 4'hF;
        req_data  = 32'hA3A2A1A0;
        for (int b = 0; b < 5; b++) begin
            o = b % 4;
            #1;
            chk($sformatf("rr%0d_idle_ov", b), 32'(owner_valid), 32'd0);
            chk($sformatf("rr%0d_idle_en", b), 32'(w_en), 32'd0);
            cyc();
            for (int k = 0; k < 4; k++) begin
                #1;
                chk($sformatf("rr%0d_%0d_own", b, k), 32'(owner_id), 32'(o));
                chk($sformatf("rr%0d_%0d_en", b, k), 32'(w_en), 32'd1);
                chk($sformatf("rr%0d_%0d_wd", b, k), 32'(w_data),
                    32'(8'hA0 + 8'(o)));
                chk($sformatf("rr%0d_%0d_rdy", b, k), 32'(req_ready),
                    32'(1 << o));
                cyc();
            end
        end

        // Back-pressure on owner 2 after two words
        reset_dut();
        req_valid = 4'b0100;
        req_data  = 32'h0020_0000;
        cyc();
        #1;
        chk("bp_w0", 32'(w_data), 32'h20);
        cyc();
        req_data = 32'h0021_0000;
        #1;
        chk("bp_w1", 32'(w_data), 32'h21);
        cyc();
        w_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_s%0d_en", k), 32'(w_en), 32'd0);
            chk($sformatf("bp_s%0d_rdy", k), 32'(req_ready), 32'd0);
            chk($sformatf("bp_s%0d_ov", k), 32'(owner_valid), 32'd1);
            cyc();
        end
        chk("bp_stall", 32'(stall_cnt), 32'd5);
        w_full   = 1'b0;
        req_data = 32'h0022_0000;
        #1;
        chk("bp_w2", 32'(w_data), 32'h22);
        chk("bp_w2_en", 32'(w_en), 32'd1);
        cyc();
        req_data = 32'h0023_0000;
        #1;
        chk("bp_w3", 32'(w_data), 32'h23);
        chk("bp_w3_en", 32'(w_en), 32'd1);
        cyc();
        #1;
        chk("bp_end_ov", 32'(owner_valid), 32'd0);
        chk("bp_end_en", 32'(w_en), 32'd0);

        // Owner drops valid in the same cycle w_full rises
        req_data = 32'h0024_0000;
        cyc();
        #1;
        chk("dr_own", 32'(owner_id), 32'd2);
        chk("dr_en", 32'(w_en), 32'd1);
        cyc();
        req_valid = 4'b0000;
        w_full    = 1'b1;
        #1;
        chk("dr_en0", 32'(w_en), 32'd0);
        cyc();
        #1;
        chk("dr_ov", 32'(owner_valid), 32'd0);
        chk("dr_stall", 32'(stall_cnt), 32'd5);
        w_full = 1'b0;

        // Early release by owner 1; requester 3 next
        reset_dut();
        req_valid = 4'b1010;
        req_data  = 32'h5000_3000;
        cyc();
        #1;
        chk("er_own", 32'(owner_id), 32'd1);
        chk("er_w0", 32'(w_data), 32'h30);
        cyc();
        req_data = 32'h5000_3100;
        #1;
        chk("er_w1", 32'(w_data), 32'h31);
        cyc();
        req_valid = 4'b1000;
        #1;
        chk("er_drop_en", 32'(w_en), 32'd0);
        chk("er_drop_ov", 32'(owner_valid), 32'd1);
        cyc();
        #1;
        chk("er_idle_ov", 32'(owner_valid), 32'd0);
        cyc();
        #1;
        chk("er_next_own", 32'(owner_id), 32'd3);
        chk("er_next_wd", 32'(w_data), 32'h50);
        chk("er_next_rdy", 32'(req_ready), 32'h8);

        // Asynchronous reset mid-burst
        w_full = 1'b1;
        cyc();
        chk("ar_pre_stall", 32'(stall_cnt), 32'd1);
        w_full    = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'hD3D2D1D0;
        #1;
        chk("ar_pre_en", 32'(w_en), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_en", 32'(w_en), 32'd0);
        chk("ar_rdy", 32'(req_ready), 32'd0);
        chk("ar_ov", 32'(owner_valid), 32'd0);
        chk("ar_stall", 32'(stall_cnt), 32'd0);
        chk("ar_wd", 32'(w_data), 32'd0);
        cyc();
        reset = 1'b1;
        #1;
        chk("ar_idle_ov", 32'(owner_valid), 32'd0);
        cyc();
        #1;
        chk("ar_own", 32'(owner_id), 32'd0);
        chk("ar_wd0", 32'(w_data), 32'hD0);

        // Stall counter saturation
        reset_dut();
        req_valid = 4'b0001;
        w_full    = 1'b1;
        cyc();
        bad = 0;
        for (int i = 0; i < 65535; i++) begin
            if (w_en !== 1'b0) bad++;
            cyc();
        end
        chk("sat_max", 32'(stall_cnt), 32'hFFFF);
        for (int i = 0; i < 20; i++) begin
            if (w_en !== 1'b0) bad++;
            cyc();
        end
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        chk("sat_no_wen", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
